mgnt_reg_bridge: RTL



---
 rtl/mgnt_reg_bridge.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mgnt_reg_bridge.sv
// SPI-to-management register bridge: byte-serial read/write requests to NUM_PORTS agents plus flow-table staging.
// Optional read-response timeout is compiled in with `define MGNT_REG_BRIDGE_TIMEOUT_EN.
module mgnt_reg_bridge #(
   parameter int NUM_PORTS      = 4,
   parameter int MGNT_REG_WIDTH = 32,
   parameter int FLOW_WIDTH     = 120,
   parameter int HASH_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_wr,
   input  logic [6:0]            spi_op,
   input  logic [15:0]           spi_din,
   output logic                  spi_ack,
   output logic [15:0]           spi_dout,
   output logic [1:0]            spi_status,
   output logic [NUM_PORTS-1:0]  sys_req_valid,
   output logic                  sys_req_wr,
   output logic [7:0]            sys_req_addr,
   output logic [7:0]            sys_req_data,
   input  logic                  sys_resp_valid,
   input  logic [7:0]            sys_resp_data,
   output logic                  ft_clear,
   output logic                  ft_update,
   output logic [FLOW_WIDTH-1:0] flow,
   output logic [HASH_WIDTH-1:0] hash
);

   // state      | meaning
   // S_IDLE     | waiting for a command write
   // S_DECODE   | one cycle: validate port, snapshot write data, launch request
   // S_WR_BURST | streaming BYTES write bytes MSB first
   // S_RD_WAIT  | collecting BYTES response beats
   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WR_BURST, S_RD_WAIT} state_t;

   localparam int BYTES  = MGNT_REG_WIDTH / 8;
   localparam int WORDS  = MGNT_REG_WIDTH / 16;
   localparam int RSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CNT_W  = $clog2(BYTES + 1);

   state_t                    state_q;
   logic                      busy_q;
   logic                      err_q;
   logic                      cmd_wr_q;
   logic [6:0]                cmd_port_q;
   logic [7:0]                cmd_addr_q;
   logic [MGNT_REG_WIDTH-1:0] wdata_q;
   logic [MGNT_REG_WIDTH-1:0] burst_q;
   logic [MGNT_REG_WIDTH-1:0] rd_acc_q;
   logic [MGNT_REG_WIDTH-1:0] rdata_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [NUM_PORTS-1:0]      req_valid_q;
   logic                      req_wr_q;
   logic [7:0]                req_data_q;
   logic [RSEL_W-1:0]         rsel_q;
   logic [HASH_WIDTH-1:0]     hash_q;
   logic [FLOW_WIDTH-1:0]     flow_q;
   logic [1:0]                ft_pend_q;
   logic [1:0]                ft_pend_d;
   logic                      ft_update_q;
   logic                      ft_clear_q;

`ifdef MGNT_REG_BRIDGE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0]          tmr_q;
`endif

   logic op_cmd, op_wdata, op_tbl, op_hash, op_rsel, op_err_clr;
   logic port_ok;

   assign op_cmd     = spi_wr && (spi_op == 7'h00);
   assign op_wdata   = spi_wr && (spi_op == 7'h01);
   assign op_tbl     = spi_wr && (spi_op == 7'h02);
   assign op_hash    = spi_wr && (spi_op == 7'h03);
   assign op_rsel    = spi_wr && (spi_op == 7'h04);
   assign op_err_clr = spi_wr && (spi_op == 7'h05);
   assign port_ok    = int'(cmd_port_q) < NUM_PORTS;

   assign spi_ack       = spi_wr;
   assign spi_dout      = 16'(rdata_q >> {rsel_q, 4'b0000});
   assign spi_status    = {err_q, busy_q};
   assign sys_req_valid = req_valid_q;
   assign sys_req_wr    = req_wr_q;
   assign sys_req_addr  = cmd_addr_q;
   assign sys_req_data  = req_data_q;
   assign ft_update     = ft_update_q;
   assign ft_clear      = ft_clear_q;
   assign flow          = flow_q;
   assign hash          = hash_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         cmd_wr_q    <= 1'b0;
         cmd_port_q  <= '0;
         cmd_addr_q  <= '0;
         burst_q     <= '0;
         rd_acc_q    <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
         req_valid_q <= '0;
         req_wr_q    <= 1'b0;
         req_data_q  <= '0;
`ifdef MGNT_REG_BRIDGE_TIMEOUT_EN
         tmr_q       <= '0;
`endif
      end else begin
         if (op_err_clr) err_q <= 1'b0;
         if (op_cmd && busy_q) err_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (op_cmd) begin
                  cmd_wr_q   <= spi_din[15];
                  cmd_port_q <= spi_din[14:8];
                  cmd_addr_q <= spi_din[7:0];
                  busy_q     <= 1'b1;
                  state_q    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!port_ok) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cmd_wr_q) begin
                  // Burst runs from a private copy so later 0x01 writes only stage the next command.
                  req_valid_q <= NUM_PORTS'(1) << cmd_port_q;
                  req_wr_q    <= 1'b1;
                  req_data_q  <= wdata_q[MGNT_REG_WIDTH-1 -: 8];
                  burst_q     <= wdata_q << 8;
                  cnt_q       <= CNT_W'(1);
                  state_q     <= S_WR_BURST;
               end else begin
                  req_valid_q <= NUM_PORTS'(1) << cmd_port_q;
                  req_wr_q    <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_RD_WAIT;
`ifdef MGNT_REG_BRIDGE_TIMEOUT_EN
                  tmr_q       <= TMR_W'(TIMEOUT_CYCLES);
`endif
               end
            end
            S_WR_BURST: begin
               if (cnt_q == CNT_W'(BYTES)) begin
                  req_valid_q <= '0;
                  req_wr_q    <= 1'b0;
                  req_data_q  <= '0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  req_data_q <= burst_q[MGNT_REG_WIDTH-1 -: 8];
                  burst_q    <= burst_q << 8;
                  cnt_q      <= cnt_q + CNT_W'(1);
               end
            end
            S_RD_WAIT: begin
               req_valid_q <= '0;
               if (sys_resp_valid) begin
`ifdef MGNT_REG_BRIDGE_TIMEOUT_EN
                  tmr_q <= TMR_W'(TIMEOUT_CYCLES);
`endif
                  // Beats gather in rd_acc_q; rdata_q only changes once the word is complete.
                  if (cnt_q == CNT_W'(BYTES - 1)) begin
                     rdata_q <= MGNT_REG_WIDTH'({rd_acc_q, sys_resp_data});
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     rd_acc_q <= MGNT_REG_WIDTH'({rd_acc_q, sys_resp_data});
                     cnt_q    <= cnt_q + CNT_W'(1);
                  end
               end
`ifdef MGNT_REG_BRIDGE_TIMEOUT_EN
               else if (tmr_q == TMR_W'(1)) begin
                  rdata_q <= '1;
                  cnt_q   <= '0;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdata_q <= '0;
         rsel_q  <= '0;
         hash_q  <= '0;
         flow_q  <= '0;
      end else begin
         if (op_wdata) wdata_q <= MGNT_REG_WIDTH'({wdata_q, spi_din});
         if (op_rsel)  rsel_q  <= RSEL_W'(int'(spi_din) % WORDS);
         if (op_hash)  hash_q  <= spi_din[HASH_WIDTH-1:0];
         // Walking flow bits keeps every select in range; words past the entry never match an op.
         for (int b = 0; b < FLOW_WIDTH; b++) begin
            if (spi_wr && (spi_op == 7'(48 + b / 16))) flow_q[b] <= spi_din[b % 16];
         end
      end
   end

   always_comb begin
      ft_pend_d = 2'b00;
      if (op_tbl && (ft_pend_q == 2'b00) && !ft_update_q && !ft_clear_q) begin
         if (spi_din == 16'd1)      ft_pend_d = 2'b01;
         else if (spi_din == 16'd2) ft_pend_d = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ft_pend_q   <= 2'b00;
         ft_update_q <= 1'b0;
         ft_clear_q  <= 1'b0;
      end else begin
         ft_pend_q   <= ft_pend_d;
         ft_update_q <= ft_pend_q[0];
         ft_clear_q  <= ft_pend_q[1];
      end
   end

endmodule
